pixel_write_arbiter: RTL and testbench
======================================

Name: pixel_write_arbiter

Overview:
- Shares the single frame-buffer pixel write port between three pixel producers: 0 = vector engine, 1 = sprite engine, 2 = clear/fill engine.
- Arbitrates round-robin with a bounded burst per grant, converts (x, y) to a linear frame-buffer address, and drops off-screen pixels.
- Runs a 2-stage pipeline with backpressure from the frame-buffer write port.
- Sits between the drawing engines and the frame buffer, replacing each engine's private address conversion.

Parameters:
- WIDTH, 640, visible pixels per row; address = y*WIDTH + x.
- HEIGHT, 400, visible rows.
- BURST_MAX, 16, maximum consecutive accepted beats per grant while other requesters wait; range 1..255.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  when low, no new beats are accepted; in-flight beats drain
- req_valid  in  3  per-requester pixel valid
- req_ready  out  3  per-requester accept; a beat transfers on a clk edge with valid & ready
- req_x  in  30  3 x 10-bit x coordinates, requester i in [10i+9:10i]
- req_y  in  27  3 x 9-bit y coordinates, requester i in [9i+8:9i]
- req_color  in  12  3 x 4-bit palette index, requester i in [4i+3:4i]
- wr_en  out  1  frame-buffer write strobe
- wr_addr  out  18  linear pixel address
- wr_data  out  4  palette index
- wr_ready  in  1  frame buffer can take the write this cycle
- grant_id  out  2  current holder index (0..2); debug only
- clip_count  out  16  saturating count of dropped off-screen pixels
- busy  out  1  any pipeline stage valid or any req_valid high

Behaviour:
- Reset (async, active-high): wr_en=0, wr_addr=0, wr_data=0, clip_count=0, grant_id=2 (requester 0 has first priority), beat count=0, both stage valids cleared. req_ready=0 while reset is asserted.
- Reset mid-operation discards in-flight beats; no wr_en pulse occurs after reset asserts.
- advance = !(wr_en & !wr_ready). When advance is low, every register holds its value and req_ready=0.
- Grant selection (combinational from registered holder and beat count):
  - If the holder's req_valid=1 and beats < BURST_MAX, it keeps the grant.
  - Otherwise the grant goes to the first valid requester in order holder+1, holder+2, holder (mod 3).
  - If no requester is valid, nobody is granted.
- req_ready[i] = enable & advance & (selected == i). At most one bit is set per cycle.
- On each accepted beat:
  - If the selected requester differs from the registered holder: holder <= selected, beats <= 1.
  - Otherwise beats <= beats + 1, saturating at BURST_MAX.
- A holder that deasserts valid loses its burst immediately, with no idle cycle inserted.
- Stage 1 (edge of acceptance): latches x, y, color and computes in_range = (x < WIDTH) & (y < HEIGHT).
- Stage 2 (next advancing edge):
  - If in_range: wr_en=1, wr_addr=y*WIDTH+x (18-bit, exact; max 255999), wr_data=color.
  - If out of range: wr_en=0 and clip_count += 1, saturating at 16'hFFFF.
- Latency: a beat accepted on edge N produces wr_en on edge N+2 when there is no stall. Sustained throughput is 1 pixel per clock.
- wr_en stays high with stable addr/data until wr_ready=1. The write completes on the edge where wr_en & wr_ready.
- A stage-2 bubble (no valid beat) sets wr_en=0 regardless of wr_ready.
- enable low: req_ready=0. Stages keep advancing and drain normally. Grant state and clip_count are retained.
- Simultaneous requests from all three with continuous valid: grant order 0,1,2,0…, each grant holding exactly BURST_MAX beats.
- The multiplier may be implemented as shifts and adds (640 = 512+128) or as a DSP. It must fit the 2-cycle latency; there are no extra pipeline stages.

Test Plan:
- Single pixel: req0 x=5, y=2, color=3, wr_ready=1 -> exactly one wr_en, 2 cycles after the handshake, with wr_addr=1285 and wr_data=3.
- Corner and clip:
  - x=639, y=399 -> wr_addr=255999.
  - x=640, y=0 -> no wr_en, clip_count=1.
  - y=400 -> clip_count=2.
- Burst fairness: all three requesters valid continuously for 60 beats, BURST_MAX=16 -> grant sequence 16x0, 16x1, 16x2, 12x0; no cycle has two req_ready bits set.
- Early release: req1 holding a grant drops valid after 3 beats while req2 is valid -> req2 is accepted on the very next cycle.
- Backpressure: wr_ready held low for 5 cycles mid-stream -> wr_addr and wr_data stable and req_ready=0 throughout; no beats lost or duplicated; output order matches acceptance order.
- Reset mid-burst: assert reset with both stages full -> wr_en falls immediately (async). After release, the first grant goes to requester 0 and no stale pixel is written.

Source files
------------

// File: rtl/pixel_write_arbiter_if.sv
// Bus bundle between the three pixel producers, the arbiter and the
// frame-buffer write port.
//
// Handshake rules: a producer beat transfers on a clk edge where
// req_valid[i] & req_ready[i]; a frame-buffer write completes on a clk edge
// where wr_en & wr_ready, and wr_en/wr_addr/wr_data stay stable until then.
`timescale 1ns/1ps
interface pixel_write_arbiter_if;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [29:0] req_x;
  logic [26:0] req_y;
  logic [11:0] req_color;
  logic        wr_en;
  logic [17:0] wr_addr;
  logic [3:0]  wr_data;
  logic        wr_ready;

  // Producers and frame buffer (bench / system side)
  modport master (
    output req_valid, req_x, req_y, req_color, wr_ready,
    input  req_ready, wr_en, wr_addr, wr_data
  );

  // Arbiter side
  modport slave (
    input  req_valid, req_x, req_y, req_color, wr_ready,
    output req_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/pixel_write_arbiter.sv
// Pixel write arbiter: round-robin with bounded bursts across the vector (0),
// sprite (1) and clear/fill (2) engines, (x, y) -> linear address conversion,
// off-screen clipping, two-stage pipeline stalled by frame-buffer backpressure.
`timescale 1ns/1ps
module pixel_write_arbiter #(
  parameter int WIDTH     = 640,
  parameter int HEIGHT    = 400,
  parameter int BURST_MAX = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  pixel_write_arbiter_if.slave bus,
  output logic [1:0]           grant_id,
  output logic [15:0]          clip_count,
  output logic                 busy
);

  localparam logic [10:0] X_LIMIT      = 11'(WIDTH);
  localparam logic [9:0]  Y_LIMIT      = 10'(HEIGHT);
  localparam logic [7:0]  BURST_LIM    = 8'(BURST_MAX);
  localparam logic [1:0]  ID_VECTOR    = 2'd0;
  localparam logic [1:0]  ID_SPRITE    = 2'd1;
  localparam logic [1:0]  ID_CLEAR     = 2'd2;
  localparam logic [1:0]  HOLDER_RESET = ID_CLEAR;
  localparam logic [15:0] CLIP_MAX     = 16'hFFFF;

  // Grant state: last holder and beats accepted in its current burst.
  // beats == 0 only after reset and means "no burst in progress", so the
  // first grant rotates from HOLDER_RESET and requester 0 goes first.
  logic [1:0]  holder;
  logic [7:0]  beats;

  logic        advance;
  logic        accept;
  logic        sel_valid;
  logic [1:0]  sel_id;
  logic [1:0]  cand1;
  logic [1:0]  cand2;
  logic        holder_keeps;
  logic [9:0]  sel_x;
  logic [8:0]  sel_y;
  logic [3:0]  sel_color;

  logic        s1_valid;
  logic        s1_in_range;
  logic [9:0]  s1_x;
  logic [8:0]  s1_y;
  logic [3:0]  s1_color;
  logic [17:0] s1_addr;

  function automatic logic [1:0] next_id(input logic [1:0] id);
    return (id == ID_CLEAR) ? ID_VECTOR : id + 2'd1;
  endfunction

  function automatic logic valid_of(input logic [2:0] v, input logic [1:0] id);
    case (id)
      ID_VECTOR: return v[0];
      ID_SPRITE: return v[1];
      default:   return v[2];
    endcase
  endfunction

  // The whole pipeline moves only when stage 2 is not holding an unaccepted write.
  assign advance = !(bus.wr_en && !bus.wr_ready);

  // Pick the requester for this cycle: holder continues its burst, otherwise rotate.
  always_comb begin
    cand1        = next_id(holder);
    cand2        = next_id(cand1);
    holder_keeps = valid_of(bus.req_valid, holder) && (beats != 8'd0) && (beats < BURST_LIM);
    sel_valid    = 1'b1;
    sel_id       = holder;
    if (holder_keeps) begin
      sel_id = holder;
    end else if (valid_of(bus.req_valid, cand1)) begin
      sel_id = cand1;
    end else if (valid_of(bus.req_valid, cand2)) begin
      sel_id = cand2;
    end else if (valid_of(bus.req_valid, holder)) begin
      sel_id = holder;
    end else begin
      sel_valid = 1'b0;
    end
  end

  assign accept = !reset && enable && advance && sel_valid;

  // One-hot ready toward the selected requester only.
  always_comb begin
    bus.req_ready = 3'b000;
    if (accept) begin
      case (sel_id)
        ID_VECTOR: bus.req_ready = 3'b001;
        ID_SPRITE: bus.req_ready = 3'b010;
        default:   bus.req_ready = 3'b100;
      endcase
    end
  end

  // Route the selected requester's pixel fields into stage 1.
  always_comb begin
    sel_x     = bus.req_x[29:20];
    sel_y     = bus.req_y[26:18];
    sel_color = bus.req_color[11:8];
    case (sel_id)
      ID_VECTOR: begin
        sel_x     = bus.req_x[9:0];
        sel_y     = bus.req_y[8:0];
        sel_color = bus.req_color[3:0];
      end
      ID_SPRITE: begin
        sel_x     = bus.req_x[19:10];
        sel_y     = bus.req_y[17:9];
        sel_color = bus.req_color[7:4];
      end
      default: ;
    endcase
  end

  // Track holder and burst length on every accepted beat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      holder <= HOLDER_RESET;
      beats  <= 8'd0;
    end else if (accept) begin
      if (sel_id != holder) begin
        holder <= sel_id;
        beats  <= 8'd1;
      end else if (beats < BURST_LIM) begin
        beats <= beats + 8'd1;
      end
    end
  end

  // Stage 1: capture the accepted beat and classify it as on/off screen.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid    <= 1'b0;
      s1_in_range <= 1'b0;
      s1_x        <= '0;
      s1_y        <= '0;
      s1_color    <= '0;
    end else if (advance) begin
      s1_valid <= accept;
      if (accept) begin
        s1_in_range <= ({1'b0, sel_x} < X_LIMIT) && ({1'b0, sel_y} < Y_LIMIT);
        s1_x        <= sel_x;
        s1_y        <= sel_y;
        s1_color    <= sel_color;
      end
    end
  end

  // Linear address; a constant multiplier, so 640 folds into two shifted adds.
  assign s1_addr = 18'(s1_y) * 18'(WIDTH) + 18'(s1_x);

  // Stage 2: present on-screen pixels to the frame buffer; bubbles drop wr_en.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.wr_en   <= 1'b0;
      bus.wr_addr <= '0;
      bus.wr_data <= '0;
    end else if (advance) begin
      bus.wr_en <= s1_valid && s1_in_range;
      if (s1_valid && s1_in_range) begin
        bus.wr_addr <= s1_addr;
        bus.wr_data <= s1_color;
      end
    end
  end

  // Count clipped pixels as they leave stage 1, saturating.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clip_count <= '0;
    end else if (advance && s1_valid && !s1_in_range && (clip_count != CLIP_MAX)) begin
      clip_count <= clip_count + 16'd1;
    end
  end

  assign grant_id = holder;
  assign busy     = s1_valid || bus.wr_en || (|bus.req_valid);

endmodule

// File: tb/tb_pixel_write_arbiter.sv
// Bench for pixel_write_arbiter: scenario tasks driven from one initial block,
// a monitor logging accepted beats and completed writes, and an acceptance-order
// model of the expected frame-buffer writes.
`timescale 1ns/1ps
module tb_pixel_write_arbiter;
  localparam int WIDTH     = 640;
  localparam int HEIGHT    = 400;
  localparam int BURST_MAX = 16;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [1:0]  grant_id;
  logic [15:0] clip_count;
  logic        busy;

  pixel_write_arbiter_if bus();

  pixel_write_arbiter #(
    .WIDTH(WIDTH), .HEIGHT(HEIGHT), .BURST_MAX(BURST_MAX)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .bus(bus),
    .grant_id(grant_id),
    .clip_count(clip_count),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // ---------------- monitor logs ----------------
  int          cyc = 0;
  int          last_acc = -1;
  int          multi_ready = 0;
  logic [1:0]  acc_id_q[$];
  logic [9:0]  acc_x_q[$];
  logic [8:0]  acc_y_q[$];
  logic [3:0]  acc_c_q[$];
  int          acc_cyc_q[$];
  logic [21:0] wr_q[$];
  int          wr_cyc_q[$];

  // ---------------- scoreboard ----------------
  logic [21:0] exp_q[$];
  int          exp_clips;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    last_acc <= -1;
    if (!reset) begin
      if ($countones(bus.req_ready) > 1) multi_ready <= multi_ready + 1;
      for (int i = 0; i < 3; i++) begin
        if (bus.req_valid[i] && bus.req_ready[i]) begin
          acc_id_q.push_back(2'(i));
          acc_x_q.push_back(bus.req_x[10*i +: 10]);
          acc_y_q.push_back(bus.req_y[9*i +: 9]);
          acc_c_q.push_back(bus.req_color[4*i +: 4]);
          acc_cyc_q.push_back(cyc);
          last_acc <= i;
        end
      end
      if (bus.wr_en && bus.wr_ready) begin
        wr_q.push_back({bus.wr_addr, bus.wr_data});
        wr_cyc_q.push_back(cyc);
      end
    end
  end

  // Every accepted on-screen beat becomes one write, in acceptance order;
  // every off-screen beat becomes one clip.
  task automatic build_expected();
    int a;
    exp_q.delete();
    exp_clips = 0;
    for (int k = 0; k < acc_id_q.size(); k++) begin
      if (int'(acc_x_q[k]) < WIDTH && int'(acc_y_q[k]) < HEIGHT) begin
        a = int'(acc_y_q[k]) * WIDTH + int'(acc_x_q[k]);
        exp_q.push_back({a[17:0], acc_c_q[k]});
      end else begin
        exp_clips++;
      end
    end
  endtask

  function automatic int write_mismatches();
    int n = 0;
    if (wr_q.size() != exp_q.size()) n++;
    for (int k = 0; k < wr_q.size() && k < exp_q.size(); k++)
      if (wr_q[k] !== exp_q[k]) n++;
    return n;
  endfunction

  task automatic clear_logs();
    acc_id_q.delete(); acc_x_q.delete(); acc_y_q.delete(); acc_c_q.delete();
    acc_cyc_q.delete(); wr_q.delete(); wr_cyc_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic rand_coords(input int i, input bit in_range_only);
    logic [9:0] x;
    logic [8:0] y;
    if (in_range_only) begin
      x = 10'($urandom_range(0, WIDTH - 1));
      y = 9'($urandom_range(0, HEIGHT - 1));
    end else begin
      x = 10'($urandom_range(0, 700));
      y = 9'($urandom_range(0, 450));
    end
    bus.req_x[10*i +: 10]  = x;
    bus.req_y[9*i +: 9]    = y;
    bus.req_color[4*i +: 4] = 4'($urandom_range(0, 15));
  endtask

  task automatic send_beat(input int i, input logic [9:0] x, input logic [8:0] y,
                           input logic [3:0] c);
    bit done = 0;
    @(negedge clk);
    bus.req_x[10*i +: 10]   = x;
    bus.req_y[9*i +: 9]     = y;
    bus.req_color[4*i +: 4] = c;
    bus.req_valid[i]        = 1'b1;
    for (int t = 0; t < 50 && !done; t++) begin
      #1;
      if (bus.req_ready[i]) begin
        @(posedge clk);
        done = 1;
      end
      @(negedge clk);
    end
    bus.req_valid[i] = 1'b0;
    if (!done) begin
      checks++; failures++;
      $display("FAIL send_beat_timeout: requester %0d never accepted, required acceptance within 50 cycles", i);
    end
  endtask

  task automatic drain();
    bit idle = 0;
    @(negedge clk);
    bus.req_valid = 3'b000;
    bus.wr_ready  = 1'b1;
    enable        = 1'b1;
    for (int t = 0; t < 40 && !idle; t++) begin
      @(negedge clk);
      if (!busy) idle = 1;
    end
    if (!idle) begin
      checks++; failures++;
      $display("FAIL drain_timeout: busy=%0b after 40 cycles, required 0", busy);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    bus.req_valid = 3'b111;
    for (int i = 0; i < 3; i++) rand_coords(i, 1);
    repeat (2) @(negedge clk);
    #1;
    checks++; if (bus.wr_en !== 1'b0) begin failures++; $display("FAIL reset_wr_en: got %0b want 0", bus.wr_en); end
    checks++; if (bus.wr_addr !== 18'd0) begin failures++; $display("FAIL reset_wr_addr: got %0d want 0", bus.wr_addr); end
    checks++; if (bus.wr_data !== 4'd0) begin failures++; $display("FAIL reset_wr_data: got %0d want 0", bus.wr_data); end
    checks++; if (clip_count !== 16'd0) begin failures++; $display("FAIL reset_clip_count: got %0d want 0", clip_count); end
    checks++; if (grant_id !== 2'd2) begin failures++; $display("FAIL reset_grant_id: got %0d want 2", grant_id); end
    checks++; if (bus.req_ready !== 3'b000) begin failures++; $display("FAIL reset_req_ready: got %b want 000", bus.req_ready); end
    bus.req_valid = 3'b000;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_single_pixel();
    clear_logs();
    send_beat(0, 10'd5, 9'd2, 4'd3);
    drain();
    checks++;
    if (wr_q.size() !== 1) begin
      failures++; $display("FAIL single_write_count: got %0d writes want 1", wr_q.size());
    end else begin
      checks++;
      if (wr_q[0] !== {18'd1285, 4'd3}) begin
        failures++; $display("FAIL single_addr_data: got addr=%0d data=%0d want addr=1285 data=3", wr_q[0][21:4], wr_q[0][3:0]);
      end
      checks++;
      if (acc_cyc_q.size() != 1 || wr_cyc_q[0] - acc_cyc_q[0] !== 2) begin
        failures++; $display("FAIL single_latency: got %0d cycles want 2", (acc_cyc_q.size() == 1) ? wr_cyc_q[0] - acc_cyc_q[0] : -1);
      end
    end
  endtask

  task automatic test_corner_clip();
    clear_logs();
    send_beat(0, 10'd639, 9'd399, 4'd5);
    drain();
    checks++;
    if (wr_q.size() !== 1 || wr_q[0] !== {18'd255999, 4'd5}) begin
      failures++; $display("FAIL corner_addr: got %0d writes first=%0h want 1 write addr=255999 data=5", wr_q.size(), (wr_q.size() > 0) ? wr_q[0] : 22'h0);
    end
    clear_logs();
    send_beat(2, 10'd640, 9'd0, 4'd1);
    drain();
    checks++; if (clip_count !== 16'd1) begin failures++; $display("FAIL clip_x: got clip_count=%0d want 1", clip_count); end
    send_beat(1, 10'd0, 9'd400, 4'd7);
    drain();
    checks++; if (clip_count !== 16'd2) begin failures++; $display("FAIL clip_y: got clip_count=%0d want 2", clip_count); end
    checks++; if (wr_q.size() !== 0) begin failures++; $display("FAIL clip_no_write: got %0d writes want 0", wr_q.size()); end
  endtask

  task automatic test_burst_fairness();
    int bad = 0;
    int first_bad = -1;
    logic [15:0] clip0;
    do_reset();
    clip0 = clip_count;
    clear_logs();
    multi_ready = 0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) rand_coords(i, 0);
    bus.req_valid = 3'b111;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (acc_id_q.size() >= 60) break;
      if (last_acc >= 0) rand_coords(last_acc, 0);
    end
    bus.req_valid = 3'b000;
    drain();
    build_expected();
    checks++; if (acc_id_q.size() !== 60) begin failures++; $display("FAIL fair_beats: got %0d beats want 60", acc_id_q.size()); end
    for (int k = 0; k < acc_id_q.size(); k++) begin
      if (int'(acc_id_q[k]) != (k / BURST_MAX) % 3) begin
        bad++;
        if (first_bad < 0) first_bad = k;
      end
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL fair_grant_seq: %0d wrong grants, first at beat %0d, want 16x0 16x1 16x2 12x0", bad, first_bad); end
    checks++;
    if (acc_cyc_q.size() != 60 || acc_cyc_q[59] - acc_cyc_q[0] !== 59) begin
      failures++; $display("FAIL fair_throughput: beats did not land on consecutive cycles, want 1 per clock");
    end
    checks++; if (multi_ready !== 0) begin failures++; $display("FAIL fair_one_hot: got %0d multi-ready cycles want 0", multi_ready); end
    checks++; if (write_mismatches() !== 0) begin failures++; $display("FAIL fair_writes: got %0d writes want %0d, %0d mismatches", wr_q.size(), exp_q.size(), write_mismatches()); end
    checks++; if (clip_count !== clip0 + 16'(exp_clips)) begin failures++; $display("FAIL fair_clips: got %0d want %0d", clip_count, clip0 + 16'(exp_clips)); end
  endtask

  task automatic test_early_release();
    int n1;
    logic [9:0] seen;
    do_reset();
    clear_logs();
    @(negedge clk);
    rand_coords(1, 1);
    rand_coords(2, 1);
    bus.req_valid = 3'b110;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (last_acc >= 0) rand_coords(last_acc, 1);
      n1 = 0;
      foreach (acc_id_q[k]) if (acc_id_q[k] == 2'd1) n1++;
      if (n1 >= 3) bus.req_valid[1] = 1'b0;
      if (acc_id_q.size() >= 5) break;
    end
    bus.req_valid = 3'b000;
    drain();
    build_expected();
    seen = '1;
    for (int k = 0; k < 5 && k < acc_id_q.size(); k++) seen[2*k +: 2] = acc_id_q[k];
    checks++; if (acc_id_q.size() !== 5 || seen !== {2'd2, 2'd2, 2'd1, 2'd1, 2'd1}) begin
      failures++; $display("FAIL early_grant_seq: got %0d beats ids=%b want 5 beats 1,1,1,2,2", acc_id_q.size(), seen);
    end
    checks++; if (acc_cyc_q.size() < 4 || acc_cyc_q[3] - acc_cyc_q[2] !== 1) begin
      failures++; $display("FAIL early_no_gap: req2 not accepted on the cycle right after req1's last beat");
    end
    checks++; if (write_mismatches() !== 0) begin failures++; $display("FAIL early_writes: got %0d writes want %0d", wr_q.size(), exp_q.size()); end
  endtask

  task automatic test_backpressure();
    logic [17:0] snap_addr;
    logic [3:0]  snap_data;
    int          n_before;
    clear_logs();
    @(negedge clk);
    rand_coords(0, 1);
    bus.req_valid = 3'b001;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (last_acc >= 0) rand_coords(last_acc, 1);
      if (acc_id_q.size() >= 4) break;
    end
    bus.wr_ready = 1'b0;
    #1;
    checks++; if (bus.wr_en !== 1'b1) begin failures++; $display("FAIL bp_stall_start: wr_en=%0b want 1 mid-stream", bus.wr_en); end
    snap_addr = bus.wr_addr;
    snap_data = bus.wr_data;
    n_before  = acc_id_q.size();
    for (int s = 0; s < 5; s++) begin
      checks++; if (bus.req_ready !== 3'b000) begin failures++; $display("FAIL bp_ready_c%0d: got %b want 000", s, bus.req_ready); end
      checks++; if (bus.wr_addr !== snap_addr) begin failures++; $display("FAIL bp_addr_c%0d: got %0d want %0d", s, bus.wr_addr, snap_addr); end
      checks++; if (bus.wr_data !== snap_data) begin failures++; $display("FAIL bp_data_c%0d: got %0d want %0d", s, bus.wr_data, snap_data); end
      @(negedge clk);
      #1;
    end
    checks++; if (acc_id_q.size() !== n_before) begin failures++; $display("FAIL bp_no_accept: got %0d beats want %0d", acc_id_q.size(), n_before); end
    bus.wr_ready = 1'b1;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (last_acc >= 0) rand_coords(last_acc, 1);
      if (acc_id_q.size() >= 12) break;
    end
    bus.req_valid = 3'b000;
    drain();
    build_expected();
    checks++; if (write_mismatches() !== 0 || wr_q.size() !== 12) begin
      failures++; $display("FAIL bp_order: got %0d writes want 12 in acceptance order, %0d mismatches", wr_q.size(), write_mismatches());
    end
  endtask

  task automatic test_enable();
    logic [1:0] g0;
    int n0;
    clear_logs();
    @(negedge clk);
    g0 = grant_id;
    enable = 1'b0;
    rand_coords(1, 1);
    bus.req_valid = 3'b010;
    for (int s = 0; s < 4; s++) begin
      #1;
      checks++; if (bus.req_ready !== 3'b000) begin failures++; $display("FAIL enable_ready_c%0d: got %b want 000", s, bus.req_ready); end
      @(negedge clk);
    end
    n0 = acc_id_q.size();
    checks++; if (n0 !== 0 || grant_id !== g0) begin
      failures++; $display("FAIL enable_hold: got %0d beats grant=%0d want 0 beats grant=%0d", n0, grant_id, g0);
    end
    enable = 1'b1;
    for (int t = 0; t < 20 && acc_id_q.size() == 0; t++) @(negedge clk);
    bus.req_valid = 3'b000;
    drain();
    build_expected();
    checks++; if (acc_id_q.size() !== 1 || write_mismatches() !== 0) begin
      failures++; $display("FAIL enable_resume: got %0d beats %0d writes want 1 and 1", acc_id_q.size(), wr_q.size());
    end
  endtask

  task automatic test_reset_midburst();
    clear_logs();
    @(negedge clk);
    for (int i = 0; i < 3; i++) rand_coords(i, 1);
    bus.req_valid = 3'b111;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (last_acc >= 0) rand_coords(last_acc, 1);
      if (acc_id_q.size() >= 4) break;
    end
    #2 reset = 1'b1;
    #1;
    checks++; if (bus.wr_en !== 1'b0) begin failures++; $display("FAIL rst_mid_wr_en: got %0b want 0 immediately", bus.wr_en); end
    checks++; if (bus.req_ready !== 3'b000 || grant_id !== 2'd2) begin
      failures++; $display("FAIL rst_mid_state: ready=%b grant=%0d want 000 and 2", bus.req_ready, grant_id);
    end
    clear_logs();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (last_acc >= 0) rand_coords(last_acc, 1);
      if (acc_id_q.size() >= 3) break;
    end
    bus.req_valid = 3'b000;
    drain();
    build_expected();
    checks++; if (acc_id_q.size() == 0 || acc_id_q[0] !== 2'd0) begin
      failures++; $display("FAIL rst_mid_first_grant: got %0d want 0", (acc_id_q.size() > 0) ? int'(acc_id_q[0]) : -1);
    end
    checks++; if (write_mismatches() !== 0) begin
      failures++; $display("FAIL rst_mid_stale: got %0d writes want %0d, %0d mismatches", wr_q.size(), exp_q.size(), write_mismatches());
    end
  endtask

  task automatic test_random_traffic();
    logic [15:0] clip0;
    clear_logs();
    multi_ready = 0;
    clip0 = clip_count;
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        bus.req_valid[i] = ($urandom_range(0, 9) < 7);
        rand_coords(i, 0);
      end
      bus.wr_ready = ($urandom_range(0, 3) != 0);
      enable       = ($urandom_range(0, 7) != 0);
    end
    drain();
    build_expected();
    checks++; if (write_mismatches() !== 0) begin
      failures++; $display("FAIL rand_writes: got %0d writes want %0d, %0d mismatches", wr_q.size(), exp_q.size(), write_mismatches());
    end
    checks++; if (clip_count !== clip0 + 16'(exp_clips)) begin
      failures++; $display("FAIL rand_clips: got %0d want %0d", clip_count, clip0 + 16'(exp_clips));
    end
    checks++; if (multi_ready !== 0) begin failures++; $display("FAIL rand_one_hot: got %0d multi-ready cycles want 0", multi_ready); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset         = 1'b1;
    enable        = 1'b1;
    bus.req_valid = 3'b000;
    bus.req_x     = '0;
    bus.req_y     = '0;
    bus.req_color = '0;
    bus.wr_ready  = 1'b1;
    test_reset();
    test_single_pixel();
    test_corner_clip();
    test_burst_fairness();
    test_early_release();
    test_backpressure();
    test_enable();
    test_reset_midburst();
    test_random_traffic();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded 2 ms, required completion");
    $fatal(1, "watchdog expired");
  end
endmodule
